// File: rtl/input_feeder_ctrl.sv
// Systolic-array input feeder: clears the lane shifters, loads one ARRAYWIDTH-word tile
// from the operand buffer, then holds out_en while the skewed shifters drain into the array.
`ifndef ARRAYWIDTH
`define ARRAYWIDTH 4
`endif
`ifndef DATASIZE
`define DATASIZE 8
`endif
`ifndef DSP_DELAY
`define DSP_DELAY 1
`endif

module input_feeder_ctrl #(
  parameter int ARRAYWIDTH = `ARRAYWIDTH,
  parameter int DATASIZE   = `DATASIZE,
  parameter int DSP_DELAY  = `DSP_DELAY,
  parameter int ADDR_W     = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_W-1:0]              base_addr,
  output logic                           busy,
  output logic                           done,
  output logic                           clr,
  output logic                           rd_en,
  output logic [ADDR_W-1:0]              rd_addr,
  input  logic [ARRAYWIDTH*DATASIZE-1:0] rd_data,
  output logic                           load_en,
  output logic [ARRAYWIDTH*DATASIZE-1:0] feed_data,
  output logic                           out_en
);

  localparam int S  = (2*ARRAYWIDTH-1)*DSP_DELAY;
  localparam int CW = $clog2(ARRAYWIDTH+1);
  localparam int SW = $clog2(S+1);

  typedef enum logic [2:0] {IDLE, CLR, FETCH, STREAM, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     fcnt_q, fcnt_d;
  logic [SW-1:0]     scnt_q, scnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              load_en_q;
  logic              rd_en_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      fcnt_q    <= '0;
      scnt_q    <= '0;
      addr_q    <= '0;
      load_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      scnt_q    <= scnt_d;
      addr_q    <= addr_d;
      load_en_q <= rd_en_c;
    end
  end

  // FETCH spans ARRAYWIDTH reads plus one trailing cycle in which the last word lands.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    scnt_d  = scnt_q;
    addr_d  = addr_q;
    busy    = 1'b0;
    done    = 1'b0;
    clr     = 1'b0;
    rd_en_c = 1'b0;
    out_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          fcnt_d  = '0;
          scnt_d  = '0;
          state_d = CLR;
        end
      end
      CLR: begin
        busy    = 1'b1;
        clr     = 1'b1;
        state_d = FETCH;
      end
      FETCH: begin
        busy    = 1'b1;
        rd_en_c = (fcnt_q != CW'(ARRAYWIDTH));
        if (rd_en_c) begin
          fcnt_d = fcnt_q + CW'(1);
          addr_d = addr_q + ADDR_W'(1);
        end else begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        busy   = 1'b1;
        out_en = 1'b1;
        if (scnt_q == SW'(S-1)) state_d = DONE;
        else                    scnt_d  = scnt_q + SW'(1);
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_en     = rd_en_c;
  assign rd_addr   = rd_en_c ? addr_q : '0;
  assign load_en   = load_en_q;
  assign feed_data = load_en_q ? rd_data : '0;

endmodule

// File: tb/tb_input_feeder_ctrl.sv
// Bench for input_feeder_ctrl: two instances (DSP_DELAY 1 and 2) share stimulus; a per-cycle
// expected trace is queued when a start is accepted and compared against every output cycle.
module tb_input_feeder_ctrl;

  localparam int W  = 4;
  localparam int DS = 8;
  localparam int AW = 8;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          clr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          load_en;
    logic [W*DS-1:0] feed;
    logic          out_en;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [AW-1:0] base_addr;

  logic busy1, done1, clr1, rd_en1, load_en1, out_en1;
  logic [AW-1:0] rd_addr1;
  logic [W*DS-1:0] rd_data1, feed1;
  logic busy2, done2, clr2, rd_en2, load_en2, out_en2;
  logic [AW-1:0] rd_addr2;
  logic [W*DS-1:0] rd_data2, feed2;

  rec_t q1[$];
  rec_t q2[$];
  logic idle1 = 1'b1;
  logic idle2 = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  input_feeder_ctrl #(.ARRAYWIDTH(W), .DATASIZE(DS), .DSP_DELAY(1), .ADDR_W(AW)) dut1 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .busy(busy1), .done(done1), .clr(clr1), .rd_en(rd_en1), .rd_addr(rd_addr1),
    .rd_data(rd_data1), .load_en(load_en1), .feed_data(feed1), .out_en(out_en1));

  input_feeder_ctrl #(.ARRAYWIDTH(W), .DATASIZE(DS), .DSP_DELAY(2), .ADDR_W(AW)) dut2 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .busy(busy2), .done(done2), .clr(clr2), .rd_en(rd_en2), .rd_addr(rd_addr2),
    .rd_data(rd_data2), .load_en(load_en2), .feed_data(feed2), .out_en(out_en2));

  // Buffer contents: lane 0 of the word at 0x10+k is k+1; other lanes are offset to expose packing.
  function automatic logic [W*DS-1:0] mem_word(input logic [AW-1:0] a);
    logic [W*DS-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) w[i*DS +: DS] = a - 8'h0F + 8'(16*i);
    return w;
  endfunction

  always @(posedge clk) begin
    if (rd_en1) rd_data1 <= mem_word(rd_addr1);
    if (rd_en2) rd_data2 <= mem_word(rd_addr2);
  end

  task automatic push_tile(input int which, input logic [AW-1:0] base, input int d);
    int s;
    rec_t r;
    s = (2*W-1)*d;
    for (int c = 1; c <= W+3+s; c++) begin
      r = '0;
      r.busy = 1'b1;
      r.clr  = (c == 1);
      if (c >= 2 && c <= W+1) begin
        r.rd_en   = 1'b1;
        r.rd_addr = base + 8'(c-2);
      end
      if (c >= 3 && c <= W+2) begin
        r.load_en = 1'b1;
        r.feed    = mem_word(base + 8'(c-3));
      end
      r.out_en = (c >= W+3 && c <= W+2+s);
      r.done   = (c == W+3+s);
      if (which == 1) q1.push_back(r);
      else            q2.push_back(r);
    end
  endtask

  task automatic check_one(input int which);
    rec_t e, o;
    e = '0;
    if (which == 1) begin
      if (q1.size() > 0) e = q1.pop_front();
      o = {busy1, done1, clr1, rd_en1, rd_addr1, load_en1, feed1, out_en1};
      idle1 = !e.busy;
    end else begin
      if (q2.size() > 0) e = q2.pop_front();
      o = {busy2, done2, clr2, rd_en2, rd_addr2, load_en2, feed2, out_en2};
      idle2 = !e.busy;
    end
    n_checks++;
    assert (o === e) n_pass++;
    else $error("FAIL trace_dut%0d cyc %0d: observed %h expected %h", which, cyc, o, e);
  endtask

  // Model decides acceptance from its own idle state, then one clock passes and outputs are compared.
  task automatic tick();
    if (start && rst) begin
      if (idle1) push_tile(1, base_addr, 1);
      if (idle2) push_tile(2, base_addr, 2);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_one(1);
    check_one(2);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    base_addr = '0;
    ticks(3);
    rst = 1'b1;
    ticks(2);

    // D=1 and D=2 tiles from 0x10, with starts pulsed during FETCH and STREAM
    base_addr = 8'h10;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 24; c++) begin
      start = (c == 3 || c == 8);
      base_addr = (c == 3 || c == 8) ? 8'h55 : 8'h10;
      tick();
    end
    start = 1'b0;

    // address wrap
    base_addr = 8'hFE;
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(23);

    // asynchronous reset in cycle 9 (mid-STREAM for both instances)
    base_addr = 8'h20;
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(8);
    #2 rst = 1'b0;
    #1;
    q1.delete();
    q2.delete();
    check_one(1);
    check_one(2);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    ticks(3);
    base_addr = 8'h30;
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(23);

    // back-to-back with start held high
    base_addr = 8'h40;
    start = 1'b1;
    ticks(60);
    start = 1'b0;
    for (int i = 0; i < 50 && (q1.size() > 0 || q2.size() > 0); i++) tick();
    ticks(2);
    n_checks++;
    assert (q1.size() == 0 && q2.size() == 0) n_pass++;
    else $error("FAIL drain: observed %0d/%0d records left, expected 0/0", q1.size(), q2.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
